andgate_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit bitwise AND unit between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants at most one requester per cycle, computes `a & b`, and holds the result in a single-entry output register. The result leaves through a valid/ready handshake tagged with the requester ID. The block sits between the requesting engines and the shared logic unit in the AndGate project.

---
 rtl/andgate_rr_arbiter.sv | 110 +++++++++++
 tb/tb_andgate_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/andgate_rr_arbiter.sv
// andgate_rr_arbiter
// Round-robin arbiter that lets NREQ requesters share one WIDTH-bit bitwise
// AND unit. At most one requester is accepted per cycle. Its a & b result is
// captured in a single-entry output register, which drains through a
// valid/ready handshake tagged with the requester index.
//
// Ports
//   IN_clk         clock, rising edge
//   IN_rst         synchronous active-high reset
//   IN_req_valid   [NREQ]        per-requester operand valid
//   IN_req_a       [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   IN_req_b       [NREQ*WIDTH]  operand b, requester i at [i*WIDTH +: WIDTH]
//   OUT_req_ready  [NREQ]        one-hot accept (combinational), or zero
//   OUT_res_valid  result register holds a result
//   OUT_res_x      [WIDTH]       registered a & b of the accepted request
//   OUT_res_id     [IDW]         index of the requester that produced OUT_res_x
//   IN_res_ready   consumer takes the result this cycle
module andgate_rr_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  IN_clk,
  input  logic                  IN_rst,
  input  logic [NREQ-1:0]       IN_req_valid,
  input  logic [NREQ*WIDTH-1:0] IN_req_a,
  input  logic [NREQ*WIDTH-1:0] IN_req_b,
  output logic [NREQ-1:0]       OUT_req_ready,
  output logic                  OUT_res_valid,
  output logic [WIDTH-1:0]      OUT_res_x,
  output logic [IDW-1:0]        OUT_res_id,
  input  logic                  IN_res_ready
);

  logic [IDW-1:0]   ptr;
  logic             vld_p1;
  logic [WIDTH-1:0] res_x_p1;
  logic [IDW-1:0]   res_id_p1;

  logic             can_accept;
  logic             gnt_any;
  logic [IDW-1:0]   gnt_id;
  logic [NREQ-1:0]  gnt_onehot;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  // Operand lane of one requester out of the packed bus.
  function automatic logic [WIDTH-1:0] lane(input logic [NREQ*WIDTH-1:0] bus,
                                            input logic [IDW-1:0] idx);
    return bus[int'(idx)*WIDTH +: WIDTH];
  endfunction

  // Index following idx, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + IDW'(1);
  endfunction

  assign can_accept = !vld_p1 || IN_res_ready;

  // Stage 0: rotating priority search starting at ptr. Reset suppresses any
  // grant so nothing is accepted while the block is being cleared.
  always_comb begin
    int idx;
    gnt_any    = 1'b0;
    gnt_id     = '0;
    gnt_onehot = '0;
    idx        = 0;
    if (!IN_rst && can_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!gnt_any && IN_req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    if (gnt_any) gnt_onehot[gnt_id] = 1'b1;
  end

  assign OUT_req_ready = gnt_onehot;
  assign ptr_next      = wrap_inc(gnt_id);
  assign a_sel         = lane(IN_req_a, gnt_id);
  assign b_sel         = lane(IN_req_b, gnt_id);

  // Stage 1: single-entry result register. A grant always reloads it (this
  // covers drain-and-refill in one cycle); a drain with no grant only clears
  // the valid bit so x/id keep their last values.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      vld_p1    <= 1'b0;
      res_x_p1  <= '0;
      res_id_p1 <= '0;
      ptr       <= '0;
    end else if (gnt_any) begin
      vld_p1    <= 1'b1;
      res_x_p1  <= a_sel & b_sel;
      res_id_p1 <= gnt_id;
      ptr       <= ptr_next;
    end else if (IN_res_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign OUT_res_valid = vld_p1;
  assign OUT_res_x     = res_x_p1;
  assign OUT_res_id    = res_id_p1;

endmodule

// File: tb/tb_andgate_rr_arbiter.sv
module tb_andgate_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  IN_clk = 1'b0;
  logic                  IN_rst;
  logic [NREQ-1:0]       IN_req_valid;
  logic [NREQ*WIDTH-1:0] IN_req_a;
  logic [NREQ*WIDTH-1:0] IN_req_b;
  logic [NREQ-1:0]       OUT_req_ready;
  logic                  OUT_res_valid;
  logic [WIDTH-1:0]      OUT_res_x;
  logic [IDW-1:0]        OUT_res_id;
  logic                  IN_res_ready;

  int compared   = 0;
  int mismatched = 0;

  andgate_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .IN_clk       (IN_clk),
    .IN_rst       (IN_rst),
    .IN_req_valid (IN_req_valid),
    .IN_req_a     (IN_req_a),
    .IN_req_b     (IN_req_b),
    .OUT_req_ready(OUT_req_ready),
    .OUT_res_valid(OUT_res_valid),
    .OUT_res_x    (OUT_res_x),
    .OUT_res_id   (OUT_res_id),
    .IN_res_ready (IN_res_ready)
  );

  always #5 IN_clk = ~IN_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic v, input logic [7:0] x,
                           input logic [1:0] id);
    check({tag, ".valid"}, 32'(OUT_res_valid), 32'(v));
    check({tag, ".x"},     32'(OUT_res_x),     32'(x));
    check({tag, ".id"},    32'(OUT_res_id),    32'(id));
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    IN_req_a[i*WIDTH +: WIDTH] = a;
    IN_req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Inputs change just after the falling edge; combinational ready is checked
  // 1 time unit later, registered outputs reflect the previous rising edge.
  task automatic tick();
    @(negedge IN_clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    IN_rst       = 1'b1;
    IN_req_valid = 4'b1111;
    IN_req_a     = '0;
    IN_req_b     = '0;
    IN_res_ready = 1'b0;

    // Reset held two cycles with all requesters valid: never accepted.
    tick(); settle();
    check("rst.ready0", 32'(OUT_req_ready), 32'h0);
    tick(); settle();
    check("rst.ready1", 32'(OUT_req_ready), 32'h0);
    tick();
    IN_rst       = 1'b0;
    IN_req_valid = 4'b0000;
    IN_res_ready = 1'b1;
    settle();
    check_res("rst.state", 1'b0, 8'h00, 2'd0);
    check("rst.idle_ready", 32'(OUT_req_ready), 32'h0);

    // Round-robin: all valid, a=FF, b=i -> ids and x 0,1,2,3,0,1.
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'hFF, 8'(i));
    IN_req_valid = 4'b1111;
    settle();
    check("rr.ready_first", 32'(OUT_req_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_res($sformatf("rr.res%0d", k), 1'b1, 8'(k % 4), 2'(k % 4));
      if (k < 5) begin
        settle();
        check($sformatf("rr.ready%0d", k), 32'(OUT_req_ready), 32'(1 << ((k + 1) % 4)));
      end
    end

    // Single request from req1 while ptr=2 and the register drains.
    IN_req_valid = 4'b0010;
    set_ops(1, 8'hF0, 8'h3C);
    settle();
    check("single.ready", 32'(OUT_req_ready), 32'b0010);
    tick();
    check_res("single.res", 1'b1, 8'h30, 2'd1);

    // Load id=2, x=0F as the pending result (ptr=2 after req1).
    IN_req_valid = 4'b0100;
    set_ops(2, 8'h0F, 8'hFF);
    settle();
    check("bp.load_ready", 32'(OUT_req_ready), 32'b0100);
    tick();
    check_res("bp.loaded", 1'b1, 8'h0F, 2'd2);

    // Backpressure three cycles with req3 waiting.
    IN_res_ready = 1'b0;
    IN_req_valid = 4'b1000;
    set_ops(3, 8'hAA, 8'h0F);
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("bp.ready%0d", k), 32'(OUT_req_ready), 32'h0);
      tick();
      check_res($sformatf("bp.hold%0d", k), 1'b1, 8'h0F, 2'd2);
    end
    IN_res_ready = 1'b1;
    settle();
    check("bp.release_ready", 32'(OUT_req_ready), 32'b1000);
    tick();
    check_res("bp.after", 1'b1, 8'h0A, 2'd3);

    // Pointer wrap: ptr=0, only req0 and req2 valid.
    IN_req_valid = 4'b0101;
    set_ops(0, 8'h55, 8'hFF);
    set_ops(2, 8'hC3, 8'h3C);
    settle();
    check("wrap.ready0", 32'(OUT_req_ready), 32'b0001);
    tick();
    check_res("wrap.res0", 1'b1, 8'h55, 2'd0);
    settle();
    check("wrap.ready2", 32'(OUT_req_ready), 32'b0100);
    tick();
    check_res("wrap.res2", 1'b1, 8'h00, 2'd2);

    // Put id=1 in the register (ptr=3 -> search 3,0,1), leaving ptr=2.
    IN_req_valid = 4'b0010;
    set_ops(1, 8'h12, 8'hFF);
    settle();
    check("mid.load_ready", 32'(OUT_req_ready), 32'b0010);
    tick();
    check_res("mid.loaded", 1'b1, 8'h12, 2'd1);

    // Mid-operation reset with everything valid.
    IN_rst       = 1'b1;
    IN_req_valid = 4'b1111;
    set_ops(0, 8'h3C, 8'h0F);
    settle();
    check("mid.rst_ready", 32'(OUT_req_ready), 32'h0);
    tick();
    IN_rst = 1'b0;
    check_res("mid.cleared", 1'b0, 8'h00, 2'd0);
    settle();
    check("mid.first_ready", 32'(OUT_req_ready), 32'b0001);
    tick();
    check_res("mid.first_res", 1'b1, 8'h0C, 2'd0);

    // Drain with nothing valid: valid drops, x/id keep their values.
    IN_req_valid = 4'b0000;
    tick();
    check_res("drain", 1'b0, 8'h0C, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
